// File: rtl/clock_set_controller_if.sv
// Front-panel / counter bundle for clock_set_controller.
// The slave modport is the controller's view; master is the buttons plus counter side.
interface clock_set_controller_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic       tick_en;
  logic       load;
  logic [4:0] ld_hr;
  logic [5:0] ld_min;
  logic [5:0] ld_sec;
  logic [1:0] mode;
  logic       blink;

  modport slave (
    input  btn_mode, btn_inc, cur_hr, cur_min,
    output tick_en, load, ld_hr, ld_min, ld_sec, mode, blink
  );

  modport master (
    output btn_mode, btn_inc, cur_hr, cur_min,
    input  tick_en, load, ld_hr, ld_min, ld_sec, mode, blink
  );
endinterface

// File: rtl/clock_set_controller.sv
// Mode/set sequencer for the digital clock: 1 Hz tick prescaler, hour/minute edit FSM, one-cycle load.
// Optional macro CLK_SET_BLINK_EN builds a blink divider for the edit display.
module clock_set_controller #(
  parameter int CLK_DIV   = 50,
  parameter int BLINK_DIV = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  clock_set_controller_if.slave  bus
);
  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  state_t        r_state, w_state_next;
  logic [PW-1:0] r_presc, w_presc_next;
  logic [4:0]    r_edit_hr, w_edit_hr_next;
  logic [5:0]    r_edit_min, w_edit_min_next;
  logic          r_tick, w_tick_next;
  logic          r_load, w_load_next;
  logic [4:0]    r_ld_hr, w_ld_hr_next;
  logic [5:0]    r_ld_min, w_ld_min_next;
  logic          r_blink, w_blink_next;
  logic          w_in_set_next;

  always_comb begin
    w_state_next    = r_state;
    w_presc_next    = r_presc;
    w_edit_hr_next  = r_edit_hr;
    w_edit_min_next = r_edit_min;
    w_tick_next     = 1'b0;
    w_ld_hr_next    = r_ld_hr;
    w_ld_min_next   = r_ld_min;
    case (r_state)
      RUN: begin
        if (bus.btn_mode) begin
          // Leaving RUN suppresses a coincident tick so the captured time stays valid.
          w_state_next    = SET_HR;
          w_presc_next    = '0;
          w_edit_hr_next  = bus.cur_hr;
          w_edit_min_next = bus.cur_min;
        end else begin
          w_tick_next  = (r_presc == PRESC_MAX);
          w_presc_next = (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
        end
      end
      SET_HR: begin
        w_presc_next = '0;
        if (bus.btn_mode) begin
          w_state_next = SET_MIN;
        end else if (bus.btn_inc) begin
          w_edit_hr_next = (r_edit_hr == 5'd23) ? 5'd0 : r_edit_hr + 5'd1;
        end
      end
      SET_MIN: begin
        w_presc_next = '0;
        if (bus.btn_mode) begin
          w_state_next  = COMMIT;
          w_ld_hr_next  = r_edit_hr;
          w_ld_min_next = r_edit_min;
        end else if (bus.btn_inc) begin
          w_edit_min_next = (r_edit_min == 6'd59) ? 6'd0 : r_edit_min + 6'd1;
        end
      end
      default: begin
        // COMMIT counts as prescaler slot 0, so the first tick lands CLK_DIV cycles after it.
        w_state_next = RUN;
        w_presc_next = PW'(1);
      end
    endcase
    w_load_next = (w_state_next == COMMIT);
  end

  assign w_in_set_next = (w_state_next == SET_HR) || (w_state_next == SET_MIN);

`ifdef CLK_SET_BLINK_EN
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] r_bcnt, w_bcnt_next;

  always_comb begin
    w_bcnt_next  = '0;
    w_blink_next = 1'b0;
    if (w_in_set_next) begin
      if (w_state_next != r_state) begin
        w_blink_next = 1'b1;
      end else if (r_bcnt == BLINK_MAX) begin
        w_blink_next = ~r_blink;
      end else begin
        w_bcnt_next  = r_bcnt + 1'b1;
        w_blink_next = r_blink;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_bcnt <= '0;
    else      r_bcnt <= w_bcnt_next;
  end
`else
  assign w_blink_next = w_in_set_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= RUN;
      r_presc    <= '0;
      r_edit_hr  <= '0;
      r_edit_min <= '0;
      r_tick     <= 1'b0;
      r_load     <= 1'b0;
      r_ld_hr    <= '0;
      r_ld_min   <= '0;
      r_blink    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_presc    <= w_presc_next;
      r_edit_hr  <= w_edit_hr_next;
      r_edit_min <= w_edit_min_next;
      r_tick     <= w_tick_next;
      r_load     <= w_load_next;
      r_ld_hr    <= w_ld_hr_next;
      r_ld_min   <= w_ld_min_next;
      r_blink    <= w_blink_next;
    end
  end

  assign bus.tick_en = r_tick;
  assign bus.load    = r_load;
  assign bus.ld_hr   = r_ld_hr;
  assign bus.ld_min  = r_ld_min;
  assign bus.ld_sec  = 6'd0;
  assign bus.mode    = r_state;
  assign bus.blink   = r_blink;
endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed scenarios plus random button traffic against a
// time-since-event reference model (ticks every CLK_DIV cycles after reset or commit).
module tb_clock_set_controller;
  localparam int CLK_DIV   = 4;
  localparam int BLINK_DIV = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  clock_set_controller_if bus ();

  clock_set_controller #(.CLK_DIV(CLK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: mode, edit values, edges since run origin / set entry.
  int m_st = 0, m_hr = 0, m_min = 0, m_runage = 0, m_setage = 0;
  logic       e_tick = 0, e_load = 0, e_blink = 0;
  logic [4:0] e_ld_hr = 0;
  logic [5:0] e_ld_min = 0;
  logic [1:0] e_mode = 0;

  task automatic model_edge(input bit r, input bit bm, input bit bi, input int chr, input int cmin);
    if (!r) begin
      m_st = 0; m_hr = 0; m_min = 0; m_runage = 0; m_setage = 0;
      e_ld_hr = 0; e_ld_min = 0;
    end else begin
      case (m_st)
        0: if (bm) begin m_hr = chr; m_min = cmin; m_st = 1; m_setage = 0; end
           else m_runage++;
        1: if (bm) begin m_st = 2; m_setage = 0; end
           else begin if (bi) m_hr = (m_hr + 1) % 24; m_setage++; end
        2: if (bm) begin m_st = 3; m_runage = 0; e_ld_hr = 5'(m_hr); e_ld_min = 6'(m_min); end
           else begin if (bi) m_min = (m_min + 1) % 60; m_setage++; end
        default: begin m_st = 0; m_runage++; end
      endcase
    end
    e_mode = 2'(m_st);
    e_load = (m_st == 3);
    e_tick = (m_st == 0) && (m_runage > 0) && (m_runage % CLK_DIV == 0);
    if (m_st == 1 || m_st == 2) begin
`ifdef CLK_SET_BLINK_EN
      e_blink = ((m_setage / BLINK_DIV) % 2 == 0);
`else
      e_blink = 1'b1;
`endif
    end else begin
      e_blink = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit bm, input bit bi);
    rst = r; bus.btn_mode = bm; bus.btn_inc = bi;
    @(posedge clk);
    model_edge(r, bm, bi, int'(bus.cur_hr), int'(bus.cur_min));
    #1;
    rst = 1'b1; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
  endtask

  function automatic logic [21:0] obs_vec();
    return {bus.tick_en, bus.load, bus.ld_hr, bus.ld_min, bus.ld_sec, bus.mode, bus.blink};
  endfunction

  function automatic logic [21:0] exp_vec();
    return {e_tick, e_load, e_ld_hr, e_ld_min, 6'd0, e_mode, e_blink};
  endfunction

  task automatic test_reset();
    int ticks = 0;
    step(0, 0, 0); step(0, 1, 1);
    vectors++;
    if (obs_vec() !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_state: dut=%h required=%h", obs_vec(), 22'd0);
    end
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      ticks += int'(bus.tick_en);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL free_run cycle %0d: dut=%h model=%h", i + 1, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (ticks != 5) begin
      miscompares++;
      $display("FAIL free_run_tick_count: dut=%0d required=5", ticks);
    end
  endtask

  task automatic test_full_set();
    bit seq_m[$];
    bit seq_i[$];
    int loads = 0, commit_at = -1, first_tick = -1;
    logic [4:0] got_hr = 5'h1f;
    logic [5:0] got_min = 6'h3f;
    logic [1:0] modes[$];
    bus.cur_hr = 5'd10; bus.cur_min = 6'd59;
    seq_m.push_back(1); seq_i.push_back(0);
    for (int k = 0; k < 14; k++) begin seq_m.push_back(0); seq_i.push_back(1); end
    seq_m.push_back(1); seq_i.push_back(0);
    seq_m.push_back(0); seq_i.push_back(1);
    seq_m.push_back(1); seq_i.push_back(0);
    for (int k = 0; k < 6; k++) begin seq_m.push_back(0); seq_i.push_back(0); end
    modes.push_back(bus.mode);
    for (int i = 0; i < seq_m.size(); i++) begin
      step(1, seq_m[i], seq_i[i]);
      if (bus.mode != modes[$]) modes.push_back(bus.mode);
      if (bus.load) begin loads++; commit_at = i; got_hr = bus.ld_hr; got_min = bus.ld_min; end
      if (bus.tick_en && commit_at >= 0 && first_tick < 0) first_tick = i;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL full_set step %0d: dut=%h model=%h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (loads != 1 || got_hr !== 5'd0 || got_min !== 6'd0 || bus.ld_sec !== 6'd0) begin
      miscompares++;
      $display("FAIL full_set_load: loads=%0d ld_hr=%0d ld_min=%0d ld_sec=%0d required 1/0/0/0",
               loads, got_hr, got_min, bus.ld_sec);
    end
    vectors++;
    if (modes.size() != 5 || modes[0] != 2'd0 || modes[1] != 2'd1 || modes[2] != 2'd2 ||
        modes[3] != 2'd3 || modes[4] != 2'd0) begin
      miscompares++;
      $display("FAIL full_set_modes: dut sequence length %0d required 0,1,2,3,0", modes.size());
    end
    vectors++;
    if (first_tick - commit_at != CLK_DIV) begin
      miscompares++;
      $display("FAIL full_set_first_tick: dut=%0d cycles after COMMIT required=%0d",
               first_tick - commit_at, CLK_DIV);
    end
  endtask

  task automatic test_simultaneous();
    bus.cur_hr = 5'd5; bus.cur_min = 6'd20;
    step(1, 1, 0);
    step(1, 1, 1);
    vectors++;
    if (bus.mode !== 2'd2 || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL simultaneous_mode: dut mode=%0d required=2 (dut=%h model=%h)",
               bus.mode, obs_vec(), exp_vec());
    end
    step(1, 1, 0);
    vectors++;
    if (bus.load !== 1'b1 || bus.ld_hr !== 5'd5 || bus.ld_min !== 6'd20) begin
      miscompares++;
      $display("FAIL simultaneous_load: dut load=%b ld_hr=%0d ld_min=%0d required 1/5/20",
               bus.load, bus.ld_hr, bus.ld_min);
    end
    step(1, 0, 0);
  endtask

  task automatic test_reset_mid_edit();
    int loads = 0, ticks = 0;
    bus.cur_hr = 5'd7; bus.cur_min = 6'd30;
    step(1, 1, 0); step(1, 1, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 1);
    step(0, 0, 0);
    vectors++;
    if (bus.mode !== 2'd0 || bus.load !== 1'b0 || bus.blink !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_edit: dut mode=%0d load=%b blink=%b required 0/0/0",
               bus.mode, bus.load, bus.blink);
    end
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0);
      loads += int'(bus.load);
      ticks += int'(bus.tick_en);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid_edit cycle %0d: dut=%h model=%h", i + 1, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (loads != 0 || ticks != 3) begin
      miscompares++;
      $display("FAIL reset_mid_edit_resume: loads=%0d ticks=%0d required 0/3", loads, ticks);
    end
  endtask

  task automatic test_no_tick_while_set();
    int ticks = 0;
    step(1, 1, 0);
    for (int i = 0; i < 30; i++) begin
      step(1, 0, 0);
      ticks += int'(bus.tick_en);
    end
    vectors++;
    if (ticks != 0 || bus.mode !== 2'd1) begin
      miscompares++;
      $display("FAIL no_tick_while_set: ticks=%0d mode=%0d required 0/1", ticks, bus.mode);
    end
    step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1);
      vectors++;
      if (bus.mode !== 2'd0 || obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL inc_in_run %0d: dut=%h model=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_blink();
    logic req;
    step(1, 0, 0);
    vectors++;
    if (bus.blink !== 1'b0) begin
      miscompares++;
      $display("FAIL blink_run: dut=%b required=0", bus.blink);
    end
    step(1, 1, 0);
    for (int k = 0; k < 8; k++) begin
`ifdef CLK_SET_BLINK_EN
      req = ((k / BLINK_DIV) % 2 == 0);
`else
      req = 1'b1;
`endif
      vectors++;
      if (bus.blink !== req) begin
        miscompares++;
        $display("FAIL blink_set_hr k=%0d: dut=%b required=%b", k, bus.blink, req);
      end
      step(1, 0, 0);
    end
    step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    vectors++;
    if (bus.blink !== 1'b0) begin
      miscompares++;
      $display("FAIL blink_after_commit: dut=%b required=0", bus.blink);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.cur_hr  = 5'($urandom_range(23, 0));
      bus.cur_min = 6'($urandom_range(59, 0));
      step(($urandom_range(79, 0) != 0), ($urandom_range(5, 0) == 0), ($urandom_range(2, 0) == 0));
      vectors++;
      if (obs_vec() !== exp_vec() || (bus.load && bus.tick_en)) begin
        miscompares++;
        $display("FAIL random step %0d: dut=%h model=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    bus.cur_hr = 5'd0;   bus.cur_min = 6'd0;
    test_reset();
    test_full_set();
    test_simultaneous();
    test_reset_mid_edit();
    test_no_tick_while_set();
    test_blink();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
